// File: rtl/riscv_check_pkg.sv
// Shared types and width helpers for the commit checker slice.
package riscv_check_pkg;

  // Explicit encodings keep the legacy state values visible in waveforms.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_006F;  // jal x0,0

  // Width of an index into n entries (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/check_regfile.sv
// Register table with per-entry valid mask: one write port, one async read port.
module check_regfile
  import riscv_check_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          we,
  input  logic [idx_w(NUM_REGS)-1:0]    waddr,
  input  logic [XLEN-1:0]               wdata,
  input  logic [idx_w(NUM_REGS)-1:0]    raddr,
  output logic [XLEN-1:0]               rdata,
  output logic                          rvalid
);

  logic [XLEN-1:0]     mem [NUM_REGS];
  logic [NUM_REGS-1:0] valid;

  // Storage update: reset or clear wipes data and valid bits, else single write.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (we) begin
      mem[waddr]   <= wdata;
      valid[waddr] <= 1'b1;
    end
  end

  assign rdata  = mem[raddr];
  assign rvalid = valid[raddr];

endmodule

// File: rtl/riscv_commit_checker.sv
// Snoops write-back/fetch, detects halt or timeout, then scans shadow vs expected table.
module riscv_commit_checker
  import riscv_check_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     NUM_REGS        = 32,
  parameter int unsigned     MAX_CYCLES      = 50,
  parameter int unsigned     MIN_HALT_CYCLES = 5,
  parameter logic [XLEN-1:0] HALT_INSTR      = XLEN'(DEFAULT_HALT_INSTR)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          instr_valid,
  input  logic [XLEN-1:0]               instr,
  input  logic                          wb_en,
  input  logic [idx_w(NUM_REGS)-1:0]    wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          exp_we,
  input  logic [idx_w(NUM_REGS)-1:0]    exp_addr,
  input  logic [XLEN-1:0]               exp_data,
  input  logic                          exp_clear,
  output logic                          busy,
  output logic                          done,
  output logic                          all_pass,
  output logic                          timeout,
  output logic [cnt_w(NUM_REGS)-1:0]    check_cnt,
  output logic [cnt_w(NUM_REGS)-1:0]    pass_cnt,
  output logic                          mm_valid,
  output logic [idx_w(NUM_REGS)-1:0]    mm_idx,
  output logic [XLEN-1:0]               mm_got,
  output logic [XLEN-1:0]               mm_exp
);

  localparam int unsigned IW  = idx_w(NUM_REGS);
  localparam int unsigned CW  = cnt_w(NUM_REGS);
  localparam int unsigned CYW = cnt_w(MAX_CYCLES);

  localparam logic [CYW-1:0] LAST_CYCLE = CYW'(MAX_CYCLES - 1);
  localparam logic [CYW-1:0] MIN_HALT   = CYW'(MIN_HALT_CYCLES);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_REGS - 1);

  state_t         state;
  logic [CYW-1:0] cycle_cnt;
  logic [IW-1:0]  chk_idx;

  logic            idle_or_done;
  logic            halt_hit;
  logic [XLEN-1:0] sh_data;
  logic            sh_valid;
  logic [XLEN-1:0] ex_data;
  logic            ex_valid;
  logic [XLEN-1:0] got;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign halt_hit     = instr_valid && (instr == HALT_INSTR) && (cycle_cnt > MIN_HALT);

  check_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_or_done && start),
    .we     ((state == RUN) && wb_en && (wb_rd != '0)),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr  (chk_idx),
    .rdata  (sh_data),
    .rvalid (sh_valid)
  );

  check_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_expected (
    .clk    (clk),
    .reset  (reset),
    .clear  (idle_or_done && exp_clear),
    .we     (idle_or_done && exp_we && !exp_clear),
    .waddr  (exp_addr),
    .wdata  (exp_data),
    .raddr  (chk_idx),
    .rdata  (ex_data),
    .rvalid (ex_valid)
  );

  // Unwritten shadow entries read as zero; gating on valid keeps that explicit.
  assign got = sh_valid ? sh_data : '0;

  // Run/check sequencing, counters and registered mismatch report.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      chk_idx   <= '0;
      check_cnt <= '0;
      pass_cnt  <= '0;
      timeout   <= 1'b0;
      mm_valid  <= 1'b0;
      mm_idx    <= '0;
      mm_got    <= '0;
      mm_exp    <= '0;
    end else begin
      mm_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cycle_cnt <= '0;
            check_cnt <= '0;
            pass_cnt  <= '0;
            timeout   <= 1'b0;
          end
        end
        RUN: begin
          cycle_cnt <= cycle_cnt + CYW'(1);
          if (halt_hit) begin
            state   <= CHECK;
            chk_idx <= '0;
            timeout <= 1'b0;
          end else if (cycle_cnt == LAST_CYCLE) begin
            state   <= CHECK;
            chk_idx <= '0;
            timeout <= 1'b1;
          end
        end
        CHECK: begin
          if (ex_valid) begin
            check_cnt <= check_cnt + CW'(1);
            if (got == ex_data) begin
              pass_cnt <= pass_cnt + CW'(1);
            end else begin
              mm_valid <= 1'b1;
              mm_idx   <= chk_idx;
              mm_got   <= got;
              mm_exp   <= ex_data;
            end
          end
          if (chk_idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            chk_idx <= chk_idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == RUN) || (state == CHECK);
  assign done     = (state == DONE);
  assign all_pass = done && (pass_cnt == check_cnt) && !timeout;

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Randomized + directed bench for riscv_commit_checker against a run-level model.
module tb_riscv_commit_checker;

  localparam int RUNLEN = 50;
  localparam int NREG   = 32;
  localparam logic [31:0] HALT = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        reset, start, instr_valid, wb_en, exp_we, exp_clear;
  logic [31:0] instr, wb_data, exp_data;
  logic [4:0]  wb_rd, exp_addr;
  logic        busy, done, all_pass, timeout, mm_valid;
  logic [5:0]  check_cnt, pass_cnt;
  logic [4:0]  mm_idx;
  logic [31:0] mm_got, mm_exp;

  riscv_commit_checker #(
    .XLEN(32), .NUM_REGS(32), .MAX_CYCLES(50), .MIN_HALT_CYCLES(5), .HALT_INSTR(HALT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .instr_valid(instr_valid), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .exp_we(exp_we), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_clear(exp_clear), .busy(busy), .done(done), .all_pass(all_pass),
    .timeout(timeout), .check_cnt(check_cnt), .pass_cnt(pass_cnt), .mm_valid(mm_valid),
    .mm_idx(mm_idx), .mm_got(mm_got), .mm_exp(mm_exp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-cycle program stimulus for one run.
  bit          p_wb_en [RUNLEN];
  bit [4:0]    p_rd    [RUNLEN];
  bit [31:0]   p_data  [RUNLEN];
  bit          p_iv    [RUNLEN];
  bit [31:0]   p_instr [RUNLEN];
  bit          p_start [RUNLEN];
  bit          p_expwe [RUNLEN];

  // Reference model state.
  bit [31:0] m_tab [NREG];
  bit        m_v   [NREG];
  int        m_exit, m_check, m_pass;
  bit        m_to;
  int        m_idx [$];
  bit [31:0] m_got [$];
  bit [31:0] m_exp [$];

  // Observations from the DUT.
  int          obs_busy;
  bit          obs_done;
  int          o_idx [$];
  logic [31:0] o_got [$];
  logic [31:0] o_exp [$];

  task automatic idle_inputs();
    start = 0; instr_valid = 0; instr = '0; wb_en = 0; wb_rd = '0; wb_data = '0;
    exp_we = 0; exp_addr = '0; exp_data = '0; exp_clear = 0;
  endtask

  task automatic load_exp(input int a, input bit [31:0] d);
    exp_we = 1; exp_addr = 5'(a); exp_data = d;
    @(negedge clk);
    exp_we = 0;
    m_tab[a] = d; m_v[a] = 1;
  endtask

  task automatic clear_exp();
    exp_clear = 1;
    @(negedge clk);
    exp_clear = 0;
    foreach (m_v[i]) m_v[i] = 0;
  endtask

  task automatic clear_prog();
    for (int c = 0; c < RUNLEN; c++) begin
      p_wb_en[c] = 0; p_rd[c] = '0; p_data[c] = '0; p_start[c] = 0; p_expwe[c] = 0;
      p_iv[c] = 1'($urandom_range(0, 1));
      p_instr[c] = $urandom;
      if (p_instr[c] == HALT) p_instr[c] = p_instr[c] ^ 32'h1;
    end
  endtask

  task automatic set_wb(input int c, input int rd, input bit [31:0] d);
    p_wb_en[c] = 1; p_rd[c] = 5'(rd); p_data[c] = d;
  endtask

  task automatic set_halt(input int c);
    p_iv[c] = 1; p_instr[c] = HALT;
  endtask

  // Model: play the program cycle by cycle until halt or budget, then scan the table.
  task automatic model_run();
    bit [31:0] sh [NREG];
    foreach (sh[i]) sh[i] = '0;
    m_exit = RUNLEN - 1; m_to = 1;
    for (int c = 0; c < RUNLEN; c++) begin
      if (p_wb_en[c] && p_rd[c] != 0) sh[p_rd[c]] = p_data[c];
      if (p_iv[c] && p_instr[c] == HALT && c > 5) begin
        m_exit = c; m_to = 0;
        break;
      end
    end
    m_check = 0; m_pass = 0;
    m_idx.delete(); m_got.delete(); m_exp.delete();
    for (int i = 0; i < NREG; i++) begin
      if (m_v[i]) begin
        m_check++;
        if (sh[i] == m_tab[i]) m_pass++;
        else begin m_idx.push_back(i); m_got.push_back(sh[i]); m_exp.push_back(m_tab[i]); end
      end
    end
  endtask

  // Start a run, replay the program, record busy length and mismatch pulses.
  // abort_at >= 0 pulls reset low for one edge once that many busy cycles were seen.
  task automatic drive_run(input int abort_at);
    obs_busy = 0; obs_done = 0;
    o_idx.delete(); o_got.delete(); o_exp.delete();
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 200; c++) begin
      if (busy) obs_busy++;
      if (mm_valid) begin o_idx.push_back(int'(mm_idx)); o_got.push_back(mm_got); o_exp.push_back(mm_exp); end
      if (done) begin obs_done = 1; break; end
      if (abort_at >= 0 && obs_busy == abort_at) begin
        reset = 0;
        @(negedge clk);
        reset = 1;
        break;
      end
      if (c < RUNLEN) begin
        wb_en = p_wb_en[c]; wb_rd = p_rd[c]; wb_data = p_data[c];
        instr_valid = p_iv[c]; instr = p_instr[c]; start = p_start[c];
        exp_we = p_expwe[c]; exp_addr = p_rd[c]; exp_data = ~p_data[c];
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset.busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset.done got=%b want=0", done); end
    total++; if (all_pass !== 1'b0) begin bad++; $display("FAIL reset.all_pass got=%b want=0", all_pass); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset.timeout got=%b want=0", timeout); end
    total++; if (check_cnt !== 6'd0 || pass_cnt !== 6'd0) begin
      bad++; $display("FAIL reset.counts got=%0d/%0d want=0/0", check_cnt, pass_cnt); end
    total++; if ({mm_valid, mm_idx, mm_got, mm_exp} !== '0) begin
      bad++; $display("FAIL reset.mm got=%b/%0d/%h/%h want=all zero", mm_valid, mm_idx, mm_got, mm_exp); end
  endtask

  task automatic prog_basic(input bit [31:0] x3);
    clear_prog();
    set_wb(1, 1, 5); set_wb(2, 2, 7); set_wb(3, 3, x3);
    set_halt(8);
  endtask

  task automatic test_all_pass();
    clear_exp(); load_exp(1, 5); load_exp(2, 7); load_exp(3, 12);
    prog_basic(12); model_run(); drive_run(-1);
    total++; if (obs_busy != m_exit + 1 + NREG) begin bad++; $display("FAIL pass.busy_len got=%0d want=%0d", obs_busy, m_exit + 1 + NREG); end
    total++; if (!obs_done || done !== 1'b1) begin bad++; $display("FAIL pass.done got=%b want=1", done); end
    total++; if (check_cnt !== 6'(m_check) || pass_cnt !== 6'(m_pass)) begin
      bad++; $display("FAIL pass.counts got=%0d/%0d want=%0d/%0d", check_cnt, pass_cnt, m_check, m_pass); end
    total++; if (all_pass !== 1'b1 || timeout !== 1'b0) begin
      bad++; $display("FAIL pass.verdict got=%b/%b want=1/0", all_pass, timeout); end
    total++; if (o_idx.size() != 0) begin bad++; $display("FAIL pass.mm_pulses got=%0d want=0", o_idx.size()); end
  endtask

  task automatic test_mismatch();
    prog_basic(13); model_run(); drive_run(-1);
    total++; if (pass_cnt !== 6'(m_pass) || all_pass !== 1'b0) begin
      bad++; $display("FAIL mm.pass got=%0d/%b want=%0d/0", pass_cnt, all_pass, m_pass); end
    total++; if (o_idx.size() != m_idx.size()) begin
      bad++; $display("FAIL mm.pulses got=%0d want=%0d", o_idx.size(), m_idx.size()); end
    else if (m_idx.size() > 0) begin
      total++; if (o_idx[0] != m_idx[0] || o_got[0] !== m_got[0] || o_exp[0] !== m_exp[0]) begin
        bad++; $display("FAIL mm.report got=%0d/%0d/%0d want=%0d/%0d/%0d", o_idx[0], o_got[0], o_exp[0], m_idx[0], m_got[0], m_exp[0]); end
    end
    @(negedge clk);
    total++; if (mm_valid !== 1'b0 || mm_idx !== 5'd3 || mm_got !== 32'd13) begin
      bad++; $display("FAIL mm.hold got=%b/%0d/%0d want=0/3/13", mm_valid, mm_idx, mm_got); end
  endtask

  task automatic test_timeout();
    prog_basic(12); p_iv[8] = 0; p_instr[8] = 32'h13; set_halt(3);
    model_run(); drive_run(-1);
    total++; if (obs_busy != m_exit + 1 + NREG) begin bad++; $display("FAIL to.busy_len got=%0d want=%0d", obs_busy, m_exit + 1 + NREG); end
    total++; if (timeout !== m_to || pass_cnt !== 6'(m_pass) || all_pass !== 1'b0) begin
      bad++; $display("FAIL to.verdict got=%b/%0d/%b want=%b/%0d/0", timeout, pass_cnt, all_pass, m_to, m_pass); end
  endtask

  task automatic test_x0_lock();
    exp_clear = 1; exp_we = 1; exp_addr = 5'd9; exp_data = 32'h99;
    @(negedge clk);
    idle_inputs();
    foreach (m_v[i]) m_v[i] = 0;
    load_exp(0, 0); load_exp(1, 5); load_exp(2, 7); load_exp(3, 12);
    prog_basic(12); set_wb(5, 0, 32'hDEADBEEF);
    p_expwe[4] = 1; p_rd[4] = 5'd6;
    p_iv[8] = 0; p_instr[8] = 32'h13; set_halt(10);
    model_run(); drive_run(-1);
    total++; if (check_cnt !== 6'(m_check) || pass_cnt !== 6'(m_pass) || all_pass !== 1'b1) begin
      bad++; $display("FAIL x0.counts got=%0d/%0d/%b want=%0d/%0d/1", check_cnt, pass_cnt, all_pass, m_check, m_pass); end
  endtask

  task automatic test_halt_wb();
    clear_exp(); load_exp(4, 9);
    clear_prog(); set_wb(12, 4, 9); set_halt(12); p_start[7] = 1;
    model_run(); drive_run(-1);
    total++; if (obs_busy != m_exit + 1 + NREG || pass_cnt !== 6'(m_pass) || timeout !== 1'b0) begin
      bad++; $display("FAIL hwb.same got=%0d/%0d/%b want=%0d/%0d/0", obs_busy, pass_cnt, timeout, m_exit + 1 + NREG, m_pass); end
    clear_prog(); set_wb(49, 4, 9); set_halt(49); p_start[20] = 1;
    model_run(); drive_run(-1);
    total++; if (obs_busy != m_exit + 1 + NREG || pass_cnt !== 6'(m_pass) || timeout !== m_to || all_pass !== 1'b1) begin
      bad++; $display("FAIL hwb.last got=%0d/%0d/%b/%b want=%0d/%0d/%b/1", obs_busy, pass_cnt, timeout, all_pass, m_exit + 1 + NREG, m_pass, m_to); end
  endtask

  task automatic test_reset_mid_check();
    clear_exp(); load_exp(1, 5); load_exp(2, 7); load_exp(3, 12);
    prog_basic(12); drive_run(20);
    foreach (m_v[i]) m_v[i] = 0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || check_cnt !== 6'd0 || pass_cnt !== 6'd0 || timeout !== 1'b0) begin
      bad++; $display("FAIL rst_mid.state got=%b/%b/%0d/%0d/%b want=0/0/0/0/0", busy, done, check_cnt, pass_cnt, timeout); end
    clear_prog(); set_halt(7);
    model_run(); drive_run(-1);
    total++; if (done !== 1'b1 || check_cnt !== 6'(m_check) || all_pass !== 1'b1) begin
      bad++; $display("FAIL rst_mid.rerun got=%b/%0d/%b want=1/%0d/1", done, check_cnt, all_pass, m_check); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      clear_exp();
      for (int i = 0; i < NREG; i++)
        if ($urandom_range(0, 2) == 0) load_exp(i, 32'($urandom_range(0, 3)));
      clear_prog();
      for (int c = 0; c < RUNLEN; c++) begin
        if ($urandom_range(0, 1) == 1) set_wb(c, int'($urandom_range(0, 31)), 32'($urandom_range(0, 3)));
        p_start[c] = ($urandom_range(0, 15) == 0);
        p_expwe[c] = ($urandom_range(0, 15) == 0);
      end
      set_halt(int'($urandom_range(0, 5)));
      begin
        int h = int'($urandom_range(6, 70));
        if (h < RUNLEN) set_halt(h);
      end
      model_run(); drive_run(-1);
      total++; if (obs_busy != m_exit + 1 + NREG || !obs_done) begin
        bad++; $display("FAIL rnd%0d.busy_len got=%0d/%b want=%0d/1", it, obs_busy, obs_done, m_exit + 1 + NREG); end
      total++; if (check_cnt !== 6'(m_check) || pass_cnt !== 6'(m_pass) || timeout !== m_to) begin
        bad++; $display("FAIL rnd%0d.result got=%0d/%0d/%b want=%0d/%0d/%b", it, check_cnt, pass_cnt, timeout, m_check, m_pass, m_to); end
      total++; if (all_pass !== (m_pass == m_check && !m_to)) begin
        bad++; $display("FAIL rnd%0d.all_pass got=%b want=%b", it, all_pass, (m_pass == m_check && !m_to)); end
      total++; if (o_idx.size() != m_idx.size()) begin
        bad++; $display("FAIL rnd%0d.mm_count got=%0d want=%0d", it, o_idx.size(), m_idx.size()); end
      else begin
        for (int k = 0; k < m_idx.size(); k++) begin
          total++; if (o_idx[k] != m_idx[k] || o_got[k] !== m_got[k] || o_exp[k] !== m_exp[k]) begin
            bad++; $display("FAIL rnd%0d.mm%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", it, k, o_idx[k], o_got[k], o_exp[k], m_idx[k], m_got[k], m_exp[k]); end
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    foreach (m_v[i]) begin m_v[i] = 0; m_tab[i] = '0; end
    reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    test_reset();
    test_all_pass();
    test_mismatch();
    test_timeout();
    test_x0_lock();
    test_halt_wb();
    test_reset_mid_check();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
